// File: rtl/traffic_pkg.sv
// Shared definitions for the traffic-light request path: arbiter state
// encoding and channel indices.
package traffic_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    GRANT1 = 2'd1,
    GRANT2 = 2'd2
  } arb_state_t;

  localparam int unsigned CH1 = 0;
  localparam int unsigned CH2 = 1;

endpackage

// File: rtl/sw_debounce.sv
// Switch conditioner: multi-flop synchroniser, tick-gated debounce counter,
// and a one-cycle pulse on each accepted 0->1 level change.
module sw_debounce #(
  parameter int unsigned SYNC_STAGES    = 2,
  parameter int unsigned DEBOUNCE_TICKS = 4,
  parameter int unsigned CNT_W          = 3
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic tick_i,
  input  logic sw_i,
  output logic rise_o
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic [CNT_W-1:0]       cnt_q;
  logic                   stable_q;
  logic                   stable_d_q;
  logic                   synced;

  assign synced = sync_q[SYNC_STAGES-1];

  // Synchroniser runs every cycle; only the debounce is tick-gated.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], sw_i};
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q    <= '0;
      stable_q <= 1'b0;
    end else if (tick_i) begin
      if (synced == stable_q) begin
        cnt_q <= '0;
      end else if (cnt_q == CNT_W'(DEBOUNCE_TICKS - 1)) begin
        stable_q <= synced;
        cnt_q    <= '0;
      end else begin
        cnt_q <= cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      stable_d_q <= 1'b0;
    end else begin
      stable_d_q <= stable_q;
    end
  end

  assign rise_o = stable_q & ~stable_d_q;

endmodule

// File: rtl/sw_request_ctrl.sv
// Green-request conditioner: debounces both switches, latches presses as
// pending requests and grants them round-robin over a req/ack handshake.
module sw_request_ctrl
  import traffic_pkg::*;
#(
  parameter int unsigned SYNC_STAGES    = 2,
  parameter int unsigned DEBOUNCE_TICKS = 4,
  parameter int unsigned CNT_W          = 3
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       tick_i,
  input  logic       sw_green_1,
  input  logic       sw_green_2,
  input  logic       ack1_i,
  input  logic       ack2_i,
  output logic       req1_o,
  output logic       req2_o,
  output logic [1:0] pending_o
);

  arb_state_t state_q;
  logic [1:0] rise;
  logic [1:0] clr;
  logic       last_ch2_q;

  sw_debounce #(
    .SYNC_STAGES   (SYNC_STAGES),
    .DEBOUNCE_TICKS(DEBOUNCE_TICKS),
    .CNT_W         (CNT_W)
  ) u_db1 (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .tick_i(tick_i),
    .sw_i  (sw_green_1),
    .rise_o(rise[CH1])
  );

  sw_debounce #(
    .SYNC_STAGES   (SYNC_STAGES),
    .DEBOUNCE_TICKS(DEBOUNCE_TICKS),
    .CNT_W         (CNT_W)
  ) u_db2 (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .tick_i(tick_i),
    .sw_i  (sw_green_2),
    .rise_o(rise[CH2])
  );

  // Only an ack matching the active grant may clear a pending bit.
  always_comb begin
    clr = '0;
    if (state_q == GRANT1 && ack1_i) clr[CH1] = 1'b1;
    if (state_q == GRANT2 && ack2_i) clr[CH2] = 1'b1;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q    <= IDLE;
      pending_o  <= '0;
      last_ch2_q <= 1'b1;
      req1_o     <= 1'b0;
      req2_o     <= 1'b0;
    end else begin
      // A press edge coinciding with its ack keeps the request pending.
      pending_o <= (pending_o & ~clr) | rise;
      case (state_q)
        IDLE: begin
          req1_o <= 1'b0;
          req2_o <= 1'b0;
          if (pending_o[CH1] && (!pending_o[CH2] || last_ch2_q)) begin
            state_q <= GRANT1;
          end else if (pending_o[CH2]) begin
            state_q <= GRANT2;
          end
        end
        GRANT1: begin
          if (ack1_i) begin
            req1_o     <= 1'b0;
            last_ch2_q <= 1'b0;
            state_q    <= IDLE;
          end else begin
            req1_o <= 1'b1;
          end
        end
        GRANT2: begin
          if (ack2_i) begin
            req2_o     <= 1'b0;
            last_ch2_q <= 1'b1;
            state_q    <= IDLE;
          end else begin
            req2_o <= 1'b1;
          end
        end
        default: begin
          req1_o  <= 1'b0;
          req2_o  <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sw_request_ctrl.sv
// Table-driven bench for sw_request_ctrl with a per-cycle expected-output
// scoreboard, plus a hand sequence for the asynchronous reset mid-grant.
module tb_sw_request_ctrl;

  logic       clk_i = 1'b0;
  logic       rst_i = 1'b1;
  logic       tick_i = 1'b1;
  logic       sw_green_1 = 1'b0;
  logic       sw_green_2 = 1'b0;
  logic       ack1_i = 1'b0;
  logic       ack2_i = 1'b0;
  logic       req1_o;
  logic       req2_o;
  logic [1:0] pending_o;

  sw_request_ctrl #(
    .SYNC_STAGES   (2),
    .DEBOUNCE_TICKS(4),
    .CNT_W         (3)
  ) dut (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .tick_i    (tick_i),
    .sw_green_1(sw_green_1),
    .sw_green_2(sw_green_2),
    .ack1_i    (ack1_i),
    .ack2_i    (ack2_i),
    .req1_o    (req1_o),
    .req2_o    (req2_o),
    .pending_o (pending_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    bit       rst;
    bit       tick;
    bit       sw1;
    bit       sw2;
    bit       ack1;
    bit       ack2;
    int       n;
    bit       r1;
    bit       r2;
    bit [1:0] pend;
  } vec_t;

  typedef struct {
    int       row;
    int       cyc;
    bit       r1;
    bit       r2;
    bit [1:0] pend;
  } exp_t;

  vec_t vecs[$];
  exp_t sb[$];
  int   tests = 0;
  int   failed = 0;

  function automatic void add(bit rst, bit tick, bit sw1, bit sw2, bit ack1, bit ack2,
                              int n, bit r1, bit r2, bit [1:0] pend);
    vec_t v;
    v = '{rst, tick, sw1, sw2, ack1, ack2, n, r1, r2, pend};
    vecs.push_back(v);
  endfunction

  initial begin
    exp_t e;
    bit   seen;

    //   rst tk s1 s2 a1 a2  n  r1 r2 pend
    // reset with switches high, then tie resolved ch1 first
    add(1, 1, 1, 1, 0, 0, 3, 0, 0, 2'b00);
    add(0, 1, 1, 1, 0, 0, 6, 0, 0, 2'b00);
    add(0, 1, 1, 1, 0, 0, 2, 0, 0, 2'b11);
    add(0, 1, 1, 1, 0, 0, 2, 1, 0, 2'b11);
    add(0, 1, 1, 1, 1, 0, 1, 0, 0, 2'b10);
    add(0, 1, 1, 1, 0, 0, 1, 0, 0, 2'b10);
    add(0, 1, 1, 1, 0, 0, 1, 0, 1, 2'b10);
    add(0, 1, 1, 1, 0, 1, 1, 0, 0, 2'b00);
    add(0, 1, 1, 1, 0, 0, 1, 0, 0, 2'b00);
    // release (falling edges ignored), repeat the tie
    add(0, 1, 0, 0, 0, 0, 8, 0, 0, 2'b00);
    add(0, 1, 1, 1, 0, 0, 6, 0, 0, 2'b00);
    add(0, 1, 1, 1, 0, 0, 2, 0, 0, 2'b11);
    add(0, 1, 1, 1, 0, 0, 1, 1, 0, 2'b11);
    add(0, 1, 1, 1, 1, 0, 1, 0, 0, 2'b10);
    add(0, 1, 1, 1, 0, 0, 1, 0, 0, 2'b10);
    add(0, 1, 1, 1, 0, 0, 1, 0, 1, 2'b10);
    // stray ack1 during GRANT2, then reset mid-grant
    add(0, 1, 1, 1, 1, 0, 1, 0, 1, 2'b10);
    add(1, 1, 0, 0, 0, 0, 1, 0, 0, 2'b00);
    add(0, 1, 0, 0, 0, 0, 3, 0, 0, 2'b00);
    // clean press ch1, stray ack2 during GRANT1
    add(0, 1, 1, 0, 0, 0, 6, 0, 0, 2'b00);
    add(0, 1, 1, 0, 0, 0, 2, 0, 0, 2'b01);
    add(0, 1, 1, 0, 0, 0, 1, 1, 0, 2'b01);
    add(0, 1, 1, 0, 0, 1, 1, 1, 0, 2'b01);
    add(0, 1, 1, 0, 0, 0, 1, 1, 0, 2'b01);
    add(0, 1, 1, 0, 1, 0, 1, 0, 0, 2'b00);
    add(0, 1, 1, 0, 0, 0, 2, 0, 0, 2'b00);
    // merge: second press while req1 held yields a single grant
    add(0, 1, 0, 0, 0, 0, 8, 0, 0, 2'b00);
    add(0, 1, 1, 0, 0, 0, 6, 0, 0, 2'b00);
    add(0, 1, 1, 0, 0, 0, 2, 0, 0, 2'b01);
    add(0, 1, 1, 0, 0, 0, 1, 1, 0, 2'b01);
    add(0, 1, 0, 0, 0, 0, 6, 1, 0, 2'b01);
    add(0, 1, 1, 0, 0, 0, 7, 1, 0, 2'b01);
    add(0, 1, 1, 0, 1, 0, 1, 0, 0, 2'b00);
    add(0, 1, 1, 0, 0, 0, 3, 0, 0, 2'b00);
    // set wins: press edge lands on the ack cycle
    add(0, 1, 0, 0, 0, 0, 8, 0, 0, 2'b00);
    add(0, 1, 1, 0, 0, 0, 6, 0, 0, 2'b00);
    add(0, 1, 1, 0, 0, 0, 2, 0, 0, 2'b01);
    add(0, 1, 1, 0, 0, 0, 1, 1, 0, 2'b01);
    add(0, 1, 0, 0, 0, 0, 6, 1, 0, 2'b01);
    add(0, 1, 1, 0, 0, 0, 6, 1, 0, 2'b01);
    add(0, 1, 1, 0, 1, 0, 1, 0, 0, 2'b01);
    add(0, 1, 1, 0, 0, 0, 1, 0, 0, 2'b01);
    add(0, 1, 1, 0, 0, 0, 1, 1, 0, 2'b01);
    add(0, 1, 1, 0, 1, 0, 1, 0, 0, 2'b00);
    add(0, 1, 1, 0, 0, 0, 2, 0, 0, 2'b00);
    // debounce only advances on tick_i
    add(0, 0, 1, 1, 0, 0, 10, 0, 0, 2'b00);
    add(0, 1, 1, 1, 0, 0, 4, 0, 0, 2'b00);
    add(0, 1, 1, 1, 0, 0, 2, 0, 0, 2'b10);
    add(0, 1, 1, 1, 0, 0, 1, 0, 1, 2'b10);
    add(0, 1, 1, 1, 0, 1, 1, 0, 0, 2'b00);
    // glitch of two ticks on ch2 is rejected
    add(0, 1, 1, 0, 0, 0, 8, 0, 0, 2'b00);
    add(0, 1, 1, 1, 0, 0, 2, 0, 0, 2'b00);
    add(0, 1, 1, 0, 0, 0, 8, 0, 0, 2'b00);

    for (int i = 0; i < vecs.size(); i++) begin
      for (int c = 0; c < vecs[i].n; c++) begin
        @(negedge clk_i);
        rst_i      = vecs[i].rst;
        tick_i     = vecs[i].tick;
        sw_green_1 = vecs[i].sw1;
        sw_green_2 = vecs[i].sw2;
        ack1_i     = vecs[i].ack1;
        ack2_i     = vecs[i].ack2;
        sb.push_back('{i, c, vecs[i].r1, vecs[i].r2, vecs[i].pend});
        @(posedge clk_i);
        #1;
        e = sb.pop_front();
        tests++;
        if ({req1_o, req2_o, pending_o} !== {e.r1, e.r2, e.pend}) begin
          failed++;
          $display("FAIL row%0d cyc%0d: req1/req2/pending got %b/%b/%b expected %b/%b/%b",
                   e.row, e.cyc, req1_o, req2_o, pending_o, e.r1, e.r2, e.pend);
        end
      end
    end

    // Async reset during GRANT2 must drop outputs without a clock edge.
    @(negedge clk_i);
    ack1_i = 1'b0;
    ack2_i = 1'b0;
    tick_i = 1'b1;
    sw_green_2 = 1'b1;
    seen = 1'b0;
    for (int k = 0; k < 30 && !seen; k++) begin
      @(negedge clk_i);
      if (req2_o) seen = 1'b1;
    end
    tests++;
    if (!seen) begin
      failed++;
      $display("FAIL grant2_timeout: req2 got 0 expected 1 within 30 cycles");
    end
    #2;
    rst_i = 1'b1;
    #1;
    tests++;
    if ({req1_o, req2_o, pending_o} !== 4'b0000) begin
      failed++;
      $display("FAIL async_reset: req1/req2/pending got %b/%b/%b expected 0/0/00",
               req1_o, req2_o, pending_o);
    end
    @(negedge clk_i);
    rst_i = 1'b0;
    sw_green_2 = 1'b0;
    repeat (2) @(negedge clk_i);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
